wb_master_if: RTL and testbench
===============================

WB_MASTER_IF -- requirements
Module: wb_master_if

Interface
REQ-001 SHALL have parameter DATA_W, default 32, Wishbone data width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, Wishbone address width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum wait in cycles for ACK_I/ERR_I (used only with WB_TIMEOUT_EN).
REQ-004 SHALL have ports; clock and reset are one clock, synchronous active-high reset:
- CLK_I  in  1  clock
- RST_I  in  1  synchronous active-high reset
- I_en  in  1  request strobe, sampled in IDLE only
- I_op  in  3  BUSOP_* code
- I_addr  in  ADDR_W  byte address
- I_data  in  32  write data, right-aligned
- O_data  out  32  read result, extended
- O_busy  out  1  request in flight
- O_done  out  1  one-cycle completion pulse
- O_err  out  1  qualifies O_done as failed
- ACK_I  in  1  slave acknowledge
- ERR_I  in  1  slave error
- DAT_I  in  DATA_W  slave read data
- ADR_O  out  ADDR_W  bus address, lane bits zeroed
- DAT_O  out  DATA_W  bus write data
- SEL_O  out  DATA_W/8  byte-lane selects
- CYC_O, STB_O, WE_O  out  1 each  Wishbone classic cycle controls

Function
REQ-005 SHALL implement FSM states IDLE, BUS, DONE.
REQ-006 IDLE: I_en=1 SHALL capture op/addr/data and go to BUS if aligned, else DONE with error; I_en outside IDLE SHALL be ignored.
REQ-007 Alignment: H needs addr[0]=0; W needs addr[1:0]=0; B always aligned.
REQ-008 SHALL set lane offset = addr[log2(DATA_W/8)-1:0]; SEL_O = base mask (B 0001, H 0011, W 1111) shifted left by offset.
REQ-009 SHALL drive DAT_O with I_data shifted left by 8*offset; unselected lanes SHALL be 0.
REQ-010 BUS: CYC_O=STB_O=1, WE_O=1 for WRITE ops, all bus outputs stable until ACK_I or ERR_I sampled high.
REQ-011 On ACK_I: SHALL latch DAT_I shifted right by 8*offset, zero-extend for READBU/READHU, sign-extend (bit 7 or 15) otherwise, into O_data; go DONE. Writes leave O_data unchanged.
REQ-012 ERR_I high, alone or with ACK_I, SHALL go DONE with O_err=1; ERR_I wins and O_data is unchanged.
REQ-013 CYC_O/STB_O/WE_O/SEL_O SHALL drop on the edge that leaves BUS.
REQ-014 DONE: O_done=1 for exactly one cycle; O_err valid in that cycle only; next state IDLE.
REQ-015 O_busy SHALL be 1 in BUS and DONE, 0 in IDLE.
REQ-016 Latency: I_en at cycle 0, STB_O at 1, ACK_I at n, O_done at n+1; misaligned request gives O_done+O_err at cycle 1 with no bus cycle.

Reset
REQ-017 RST_I SHALL force IDLE; CYC_O, STB_O, WE_O, SEL_O, O_busy, O_done, O_err, O_data, DAT_O, ADR_O, timeout counter = 0.
REQ-018 Reset mid-BUS SHALL drop CYC_O/STB_O on that edge with no O_done pulse.

Configuration
REQ-019 With WB_TIMEOUT_EN defined: counter SHALL clear on entering BUS, increment per BUS cycle; reaching TIMEOUT without ACK_I/ERR_I SHALL abort to DONE with O_err=1.
REQ-020 Without WB_TIMEOUT_EN: no counter; BUS SHALL wait indefinitely.

Structure
REQ-021 BUSOP_* codes, state encoding and lane-mask constants SHALL live in shared package wb_pkg (busdefs constants reused).
REQ-022 Lane shift and extension logic SHALL be sub-module wb_lane_align (combinational, parametrised by DATA_W).

Verification
REQ-023 DATA_W=32, READB addr 0x1003, DAT_I=0x80xxxxxx, ACK after 3 cycles -> SEL_O=1000, O_data=0xFFFFFF80, O_done at cycle 4.
REQ-024 DATA_W=64, WRITEH addr 0x06, I_data=0xBEEF -> SEL_O=0xC0, DAT_O=0xBEEF<<48, WE_O=1.
REQ-025 READW addr 0x2 -> O_done+O_err at cycle 1, CYC_O never asserted.
REQ-026 ACK_I and ERR_I high in the same cycle -> O_err=1 and O_data unchanged.
REQ-027 WB_TIMEOUT_EN, TIMEOUT=4, no ACK -> abort after 4 BUS cycles with O_err=1; RST_I mid-BUS -> CYC_O=0 next edge, no O_done.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone master definitions: bus op codes, FSM states, lane masks
// and small op-decode helpers.
package wb_pkg;

    localparam logic [2:0] BUSOP_READB  = 3'd0;
    localparam logic [2:0] BUSOP_READH  = 3'd1;
    localparam logic [2:0] BUSOP_READW  = 3'd2;
    localparam logic [2:0] BUSOP_READBU = 3'd3;
    localparam logic [2:0] BUSOP_READHU = 3'd4;
    localparam logic [2:0] BUSOP_WRITEB = 3'd5;
    localparam logic [2:0] BUSOP_WRITEH = 3'd6;
    localparam logic [2:0] BUSOP_WRITEW = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } wb_state_t;

    localparam logic [3:0] LANE_B = 4'b0001;
    localparam logic [3:0] LANE_H = 4'b0011;
    localparam logic [3:0] LANE_W = 4'b1111;

    function automatic logic [3:0] op_mask(input logic [2:0] op);
        case (op)
            BUSOP_READB, BUSOP_READBU, BUSOP_WRITEB: op_mask = LANE_B;
            BUSOP_READH, BUSOP_READHU, BUSOP_WRITEH: op_mask = LANE_H;
            default:                                 op_mask = LANE_W;
        endcase
    endfunction

    function automatic logic op_is_write(input logic [2:0] op);
        op_is_write = (op >= BUSOP_WRITEB);
    endfunction

    function automatic logic op_is_unsigned(input logic [2:0] op);
        op_is_unsigned = (op == BUSOP_READBU) || (op == BUSOP_READHU);
    endfunction

    function automatic logic op_aligned(input logic [2:0] op, input logic [1:0] a);
        case (op_mask(op))
            LANE_W:  op_aligned = (a == 2'b00);
            LANE_H:  op_aligned = ~a[0];
            default: op_aligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/wb_lane_align.sv
// Combinational byte-lane steering: select mask, write-data shift and
// read-data shift with zero/sign extension.
module wb_lane_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int NB    = DATA_W / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [2:0]        op,
    input  logic [OFF_W-1:0]  off,
    input  logic [31:0]       wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [NB-1:0]     sel,
    output logic [DATA_W-1:0] wbus,
    output logic [31:0]       rext
);

    logic [DATA_W-1:0] wext;
    logic [DATA_W-1:0] bmask;
    logic [31:0]       rsh;
    logic              uns;

    assign sel = NB'(op_mask(op)) << off;

    for (genvar i = 0; i < NB; i++) begin : g_bmask
        assign bmask[8*i +: 8] = {8{sel[i]}};
    end

    assign wext = DATA_W'(wdata);
    assign wbus = (wext << {off, 3'b000}) & bmask;
    assign rsh  = 32'(rdata >> {off, 3'b000});
    assign uns  = op_is_unsigned(op);

    always_comb begin
        rext = rsh;
        case (op_mask(op))
            LANE_B:  rext = uns ? {24'b0, rsh[7:0]}  : {{24{rsh[7]}},  rsh[7:0]};
            LANE_H:  rext = uns ? {16'b0, rsh[15:0]} : {{16{rsh[15]}}, rsh[15:0]};
            default: rext = rsh;
        endcase
    end

endmodule

// File: rtl/wb_master_if.sv
// Single-transfer Wishbone classic master. Define WB_TIMEOUT_EN to abort a
// bus cycle that sees no ACK_I/ERR_I within TIMEOUT cycles.
module wb_master_if
    import wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic                I_en,
    input  logic [2:0]          I_op,
    input  logic [ADDR_W-1:0]   I_addr,
    input  logic [31:0]         I_data,
    output logic [31:0]         O_data,
    output logic                O_busy,
    output logic                O_done,
    output logic                O_err,
    input  logic                ACK_I,
    input  logic                ERR_I,
    input  logic [DATA_W-1:0]   DAT_I,
    output logic [ADDR_W-1:0]   ADR_O,
    output logic [DATA_W-1:0]   DAT_O,
    output logic [DATA_W/8-1:0] SEL_O,
    output logic                CYC_O,
    output logic                STB_O,
    output logic                WE_O
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    wb_state_t         state, nxt;
    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic              err_q;
    logic              cap, lat_rd, set_err, tmo_hit, in_bus;
    logic [NB-1:0]     sel;
    logic [DATA_W-1:0] wbus;
    logic [31:0]       rext;

    wb_lane_align #(.DATA_W(DATA_W)) u_align (
        .op    (r_op),
        .off   (r_addr[OFF_W-1:0]),
        .wdata (r_data),
        .rdata (DAT_I),
        .sel   (sel),
        .wbus  (wbus),
        .rext  (rext)
    );

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt;

    // Counter sits at zero outside BUS, so it is already clear on entry.
    always_ff @(posedge CLK_I) begin
        if (RST_I || state != ST_BUS) tmo_cnt <= '0;
        else                          tmo_cnt <= tmo_cnt + 1'b1;
    end
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge CLK_I) begin
        if (RST_I) state <= ST_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt     = state;
        cap     = 1'b0;
        lat_rd  = 1'b0;
        set_err = 1'b0;
        case (state)
            ST_IDLE: if (I_en) begin
                cap = 1'b1;
                if (op_aligned(I_op, I_addr[1:0])) nxt = ST_BUS;
                else begin
                    nxt     = ST_DONE;
                    set_err = 1'b1;
                end
            end
            ST_BUS: begin
                // ERR_I takes priority over a simultaneous ACK_I.
                if (ERR_I || (!ACK_I && tmo_hit)) begin
                    nxt     = ST_DONE;
                    set_err = 1'b1;
                end else if (ACK_I) begin
                    nxt    = ST_DONE;
                    lat_rd = !op_is_write(r_op);
                end
            end
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_op   <= '0;
            r_addr <= '0;
            r_data <= '0;
            err_q  <= 1'b0;
            O_data <= '0;
        end else begin
            err_q <= set_err;
            if (cap) begin
                r_op   <= I_op;
                r_addr <= I_addr;
                r_data <= I_data;
            end
            if (lat_rd) O_data <= rext;
        end
    end

    assign in_bus = (state == ST_BUS);
    assign CYC_O  = in_bus;
    assign STB_O  = in_bus;
    assign WE_O   = in_bus && op_is_write(r_op);
    assign SEL_O  = in_bus ? sel : '0;
    assign DAT_O  = wbus;
    assign ADR_O  = {r_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign O_busy = (state != ST_IDLE);
    assign O_done = (state == ST_DONE);
    assign O_err  = err_q && (state == ST_DONE);

endmodule

// File: tb/tb_wb_master_if.sv
// Directed bench for wb_master_if: a 32-bit and a 64-bit instance share the
// request stimulus; each scenario task checks the relevant outputs inline.
module tb_wb_master_if;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  op_i;
    logic [31:0] addr_i, wdat;
    logic        ack, er;
    logic [31:0] d32;
    logic [63:0] d64;

    logic [31:0] o_data32, o_data64;
    logic        busy32, done32, err32, busy64, done64, err64;
    logic [31:0] adr32, dat32, adr64;
    logic [63:0] dat64;
    logic [3:0]  sel32;
    logic [7:0]  sel64;
    logic        cyc32, stb32, we32, cyc64, stb64, we64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_master_if #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
        .CLK_I(clk), .RST_I(rst), .I_en(en), .I_op(op_i), .I_addr(addr_i),
        .I_data(wdat), .O_data(o_data32), .O_busy(busy32), .O_done(done32),
        .O_err(err32), .ACK_I(ack), .ERR_I(er), .DAT_I(d32), .ADR_O(adr32),
        .DAT_O(dat32), .SEL_O(sel32), .CYC_O(cyc32), .STB_O(stb32), .WE_O(we32)
    );

    wb_master_if #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(4)) dut64 (
        .CLK_I(clk), .RST_I(rst), .I_en(en), .I_op(op_i), .I_addr(addr_i),
        .I_data(wdat), .O_data(o_data64), .O_busy(busy64), .O_done(done64),
        .O_err(err64), .ACK_I(ack), .ERR_I(er), .DAT_I(d64), .ADR_O(adr64),
        .DAT_O(dat64), .SEL_O(sel64), .CYC_O(cyc64), .STB_O(stb64), .WE_O(we64)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    // Request at cycle 0, respond at cycle 1; returns in the O_done cycle.
    task automatic bus_xfer(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] r32, input logic [63:0] r64,
                            input logic a_ack, input logic a_err);
        en = 1'b1; op_i = op; addr_i = a; wdat = wd;
        tick;
        en = 1'b0; ack = a_ack; er = a_err; d32 = r32; d64 = r64;
        tick;
        ack = 1'b0; er = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; op_i = '0; addr_i = '0; wdat = '0;
        ack = 1'b0; er = 1'b0; d32 = '0; d64 = '0;
        tick; tick;
        rst = 1'b0;
        tick;
        checks++; if ({cyc32, stb32, we32, sel32} !== 7'b0) begin errors++; $display("FAIL rst_bus32 got %b exp 0", {cyc32, stb32, we32, sel32}); end
        checks++; if ({busy32, done32, err32} !== 3'b0) begin errors++; $display("FAIL rst_stat32 got %b exp 000", {busy32, done32, err32}); end
        checks++; if ({o_data32, dat32, adr32} !== 96'b0) begin errors++; $display("FAIL rst_data32 got %h exp 0", {o_data32, dat32, adr32}); end
        checks++; if ({cyc64, sel64, dat64, adr64, o_data64} !== 137'b0) begin errors++; $display("FAIL rst_64 got %h exp 0", {cyc64, sel64, dat64, adr64, o_data64}); end
    endtask

    task automatic test_readb_slow;
        en = 1'b1; op_i = BUSOP_READB; addr_i = 32'h1003; wdat = '0;
        tick;                                   // cycle 1
        en = 1'b0;
        checks++; if ({cyc32, stb32, we32} !== 3'b110) begin errors++; $display("FAIL rb_ctl c1 got %b exp 110", {cyc32, stb32, we32}); end
        checks++; if (sel32 !== 4'b1000) begin errors++; $display("FAIL rb_sel got %b exp 1000", sel32); end
        checks++; if (adr32 !== 32'h1000) begin errors++; $display("FAIL rb_adr got %h exp 00001000", adr32); end
        checks++; if (sel64 !== 8'h08) begin errors++; $display("FAIL rb_sel64 got %h exp 08", sel64); end
        tick;                                   // cycle 2
        checks++; if ({cyc32, stb32, sel32, adr32, busy32, done32} !== {2'b11, 4'b1000, 32'h1000, 2'b10}) begin errors++; $display("FAIL rb_hold c2 got %b %b %h", {cyc32, stb32}, sel32, adr32); end
        tick;                                   // cycle 3
        ack = 1'b1; d32 = 32'h8012_3456; d64 = 64'h0;
        checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL rb_early_done got %b exp 0", done32); end
        tick;                                   // cycle 4
        ack = 1'b0;
        checks++; if ({done32, err32, busy32} !== 3'b101) begin errors++; $display("FAIL rb_done c4 got %b exp 101", {done32, err32, busy32}); end
        checks++; if (o_data32 !== 32'hFFFF_FF80) begin errors++; $display("FAIL rb_data got %h exp ffffff80", o_data32); end
        checks++; if ({cyc32, stb32, sel32} !== 6'b0) begin errors++; $display("FAIL rb_drop got %b exp 0", {cyc32, stb32, sel32}); end
        tick;                                   // cycle 5
        checks++; if ({done32, busy32} !== 2'b00) begin errors++; $display("FAIL rb_idle got %b exp 00", {done32, busy32}); end
    endtask

    task automatic test_write_lanes;
        en = 1'b1; op_i = BUSOP_WRITEH; addr_i = 32'h6; wdat = 32'h0000_BEEF;
        tick;
        en = 1'b0;
        checks++; if (sel64 !== 8'hC0) begin errors++; $display("FAIL wh_sel64 got %h exp c0", sel64); end
        checks++; if (dat64 !== 64'hBEEF_0000_0000_0000) begin errors++; $display("FAIL wh_dat64 got %h exp beef000000000000", dat64); end
        checks++; if ({we64, cyc64, adr64} !== {2'b11, 32'h0}) begin errors++; $display("FAIL wh_ctl64 got we=%b cyc=%b adr=%h", we64, cyc64, adr64); end
        checks++; if ({sel32, dat32, adr32, we32} !== {4'b1100, 32'hBEEF_0000, 32'h4, 1'b1}) begin errors++; $display("FAIL wh_32 got sel=%b dat=%h adr=%h we=%b", sel32, dat32, adr32, we32); end
        ack = 1'b1;
        tick;
        ack = 1'b0;
        checks++; if ({done32, err32, o_data32} !== {2'b10, 32'hFFFF_FF80}) begin errors++; $display("FAIL wh_done got d=%b e=%b data=%h", done32, err32, o_data32); end
        tick;
    endtask

    task automatic test_read_ext;
        bus_xfer(BUSOP_READHU, 32'h2, 32'h0, 32'h8765_1234, 64'h0, 1'b1, 1'b0);
        checks++; if (o_data32 !== 32'h0000_8765) begin errors++; $display("FAIL readhu got %h exp 00008765", o_data32); end
        tick;
        bus_xfer(BUSOP_READH, 32'h2, 32'h0, 32'h8765_1234, 64'h0, 1'b1, 1'b0);
        checks++; if (o_data32 !== 32'hFFFF_8765) begin errors++; $display("FAIL readh got %h exp ffff8765", o_data32); end
        tick;
        bus_xfer(BUSOP_READW, 32'h4, 32'h0, 32'h1234_5678, 64'hCAFE_BABE_0000_0000, 1'b1, 1'b0);
        checks++; if (o_data32 !== 32'h1234_5678) begin errors++; $display("FAIL readw32 got %h exp 12345678", o_data32); end
        checks++; if (o_data64 !== 32'hCAFE_BABE) begin errors++; $display("FAIL readw64 got %h exp cafebabe", o_data64); end
        tick;
        bus_xfer(BUSOP_READBU, 32'h1, 32'h0, 32'h0000_F100, 64'h0, 1'b1, 1'b0);
        checks++; if (o_data32 !== 32'h0000_00F1) begin errors++; $display("FAIL readbu got %h exp 000000f1", o_data32); end
        tick;
    endtask

    task automatic test_misaligned;
        en = 1'b1; op_i = BUSOP_READW; addr_i = 32'h2;
        @(posedge clk);
        #1;
        checks++; if (cyc32 !== 1'b0) begin errors++; $display("FAIL mis_cyc got %b exp 0", cyc32); end
        tick;
        en = 1'b0;
        checks++; if ({done32, err32, cyc32, stb32} !== 4'b1100) begin errors++; $display("FAIL mis_w got %b exp 1100", {done32, err32, cyc32, stb32}); end
        tick;
        checks++; if ({done32, err32, busy32} !== 3'b000) begin errors++; $display("FAIL mis_after got %b exp 000", {done32, err32, busy32}); end
        en = 1'b1; op_i = BUSOP_WRITEH; addr_i = 32'h1;
        tick;
        en = 1'b0;
        checks++; if ({done32, err32, cyc32} !== 3'b110) begin errors++; $display("FAIL mis_h got %b exp 110", {done32, err32, cyc32}); end
        tick;
    endtask

    task automatic test_ack_err;
        bus_xfer(BUSOP_READW, 32'h8, 32'h0, 32'h1234_5678, 64'h0, 1'b1, 1'b1);
        checks++; if ({done32, err32} !== 2'b11) begin errors++; $display("FAIL ackerr_flags got %b exp 11", {done32, err32}); end
        checks++; if (o_data32 !== 32'h0000_00F1) begin errors++; $display("FAIL ackerr_data got %h exp 000000f1", o_data32); end
        tick;
        checks++; if (err32 !== 1'b0) begin errors++; $display("FAIL ackerr_clear got %b exp 0", err32); end
    endtask

    task automatic test_ignore_en;
        en = 1'b1; op_i = BUSOP_WRITEB; addr_i = 32'h11; wdat = 32'h0000_00A5;
        tick;
        op_i = BUSOP_READW; addr_i = 32'h40;
        tick;
        en = 1'b0;
        checks++; if ({adr32, sel32, dat32, we32} !== {32'h10, 4'b0010, 32'h0000_A500, 1'b1}) begin errors++; $display("FAIL ign_hold got adr=%h sel=%b dat=%h we=%b", adr32, sel32, dat32, we32); end
        ack = 1'b1;
        tick;
        ack = 1'b0;
        checks++; if ({done32, err32} !== 2'b10) begin errors++; $display("FAIL ign_done got %b exp 10", {done32, err32}); end
        tick;
        checks++; if ({busy32, cyc32} !== 2'b00) begin errors++; $display("FAIL ign_idle got %b exp 00", {busy32, cyc32}); end
    endtask

    task automatic test_timeout;
        en = 1'b1; op_i = BUSOP_READW; addr_i = 32'h0;
        tick;
        en = 1'b0;
`ifdef WB_TIMEOUT_EN
        tick; tick; tick;                      // cycle 4: last BUS cycle
        checks++; if ({cyc32, done32} !== 2'b10) begin errors++; $display("FAIL tmo_c4 got %b exp 10", {cyc32, done32}); end
        tick;                                  // cycle 5
        checks++; if ({done32, err32, cyc32} !== 3'b110) begin errors++; $display("FAIL tmo_abort got %b exp 110", {done32, err32, cyc32}); end
        tick;
`else
        for (int i = 0; i < 8; i++) tick;
        checks++; if ({cyc32, done32, busy32} !== 3'b101) begin errors++; $display("FAIL wait_forever got %b exp 101", {cyc32, done32, busy32}); end
        ack = 1'b1;
        tick;
        ack = 1'b0;
        tick;
`endif
    endtask

    task automatic test_reset_midbus;
        en = 1'b1; op_i = BUSOP_WRITEW; addr_i = 32'h20; wdat = 32'h1122_3344;
        tick;
        en = 1'b0;
        checks++; if (cyc32 !== 1'b1) begin errors++; $display("FAIL rmb_cyc got %b exp 1", cyc32); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++; if ({cyc32, stb32, done32, busy32, cyc64} !== 5'b0) begin errors++; $display("FAIL rmb_drop got %b exp 0", {cyc32, stb32, done32, busy32, cyc64}); end
        checks++; if ({dat32, adr32} !== 64'b0) begin errors++; $display("FAIL rmb_clr got %h exp 0", {dat32, adr32}); end
        tick;
        checks++; if ({done32, done64} !== 2'b00) begin errors++; $display("FAIL rmb_nodone got %b exp 00", {done32, done64}); end
    endtask

    initial begin
        test_reset;
        test_readb_slow;
        test_write_lanes;
        test_read_ext;
        test_misaligned;
        test_ack_err;
        test_ignore_en;
        test_timeout;
        test_reset_midbus;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
